// File: rtl/dcram_pkg.sv
// Shared types and constants for the dual-clock RAM read engine.
package dcram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int         FIFO_DEPTH   = 4;
  localparam logic [2:0] FIFO_FULL    = 3'd4;
  // Reads in flight plus words buffered may never exceed the FIFO depth.
  localparam logic [2:0] CREDIT_LIMIT = 3'd4;

endpackage

// File: rtl/sync_fifo4.sv
// Single-clock 4-entry FIFO; the head entry is read straight from storage
// registers so a pushed word is visible the cycle after the push.
module sync_fifo4
  import dcram_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [2:0]       count
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic             do_push, do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != FIFO_FULL);
    do_pop   = pop && (count_q != 3'd0);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign valid    = (count_q != 3'd0);
  assign count    = count_q;

endmodule

// File: rtl/dcram_reader.sv
// Read-side engine for the dual-clock RAM: sweeps an address window and
// streams the words out as valid/ready with a last flag.
module dcram_reader
  import dcram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  rdclock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last
);

  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rdaddr_q, rdaddr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  s1_q, s1_d, s1_last_q, s1_last_d;
  logic                  s2_q, s2_d, s2_last_q, s2_last_d;
  logic                  busy_q, busy_d, done_q, done_d;

  logic [2:0]            fifo_count;
  logic                  fifo_valid;
  logic [DATA_WIDTH:0]   fifo_out;
  logic [2:0]            credit_sum;
  logic                  can_issue;
  logic                  pop_last;

  // Stage 1 tracks the address register, stage 2 the RAM output register;
  // each carries a last tag alongside its valid bit.
  assign credit_sum = fifo_count + {2'b00, s1_q} + {2'b00, s2_q};
  assign can_issue  = (credit_sum < CREDIT_LIMIT);
  assign pop_last   = dout_valid && dout_ready && dout_last;

  // Next-state, address sequencing and read-pipeline tagging.
  always_comb begin
    state_d     = state_q;
    rdaddr_d    = rdaddr_q;
    remaining_d = remaining_q;
    s1_d        = 1'b0;
    s1_last_d   = 1'b0;
    s2_d        = s1_q;
    s2_last_d   = s1_last_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            // The start cycle itself issues the first read so base
            // appears on rdaddress in the very next cycle.
            state_d     = ST_READ;
            rdaddr_d    = base_addr;
            remaining_d = length - LEN_ONE;
            s1_d        = 1'b1;
            s1_last_d   = (length == LEN_ONE);
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (remaining_q == '0) begin
          state_d = ST_DRAIN;
        end else if (can_issue) begin
          rdaddr_d    = rdaddr_q + ADDR_ONE;
          remaining_d = remaining_q - LEN_ONE;
          s1_d        = 1'b1;
          s1_last_d   = (remaining_q == LEN_ONE);
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (pop_last && !s1_q && !s2_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Control and pipeline registers.
  always_ff @(posedge rdclock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rdaddr_q    <= '0;
      remaining_q <= '0;
      s1_q        <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_q        <= 1'b0;
      s2_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdaddr_q    <= rdaddr_d;
      remaining_q <= remaining_d;
      s1_q        <= s1_d;
      s1_last_q   <= s1_last_d;
      s2_q        <= s2_d;
      s2_last_q   <= s2_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  sync_fifo4 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk      (rdclock),
    .reset    (reset),
    .push     (s2_q),
    .push_data({s2_last_q, ram_q}),
    .pop      (dout_ready),
    .pop_data (fifo_out),
    .valid    (fifo_valid),
    .count    (fifo_count)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign rdaddress  = rdaddr_q;
  assign dout       = fifo_out[DATA_WIDTH-1:0];
  assign dout_valid = fifo_valid;
  assign dout_last  = fifo_out[DATA_WIDTH] && fifo_valid;

endmodule
